logic_analyzer_trig: RTL and testbench

Parametrised successor to the single-shot logic analyzer datapath. Adds a triggered capture engine with a circular pre-trigger buffer, a programmable post-trigger depth, and a mask/value trigger comparator. It sits between the DLX core debug probe bus and the host readout path. After capture completes, the host reads samples oldest-first through a registered read port.

---
 rtl/logic_analyzer_trig.sv | 135 +++++++++++++
 tb/tb_logic_analyzer_trig.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/logic_analyzer_trig.sv
// Triggered capture engine: circular pre-trigger buffer, mask/value trigger,
// programmable post-trigger depth and an oldest-first registered read port.
module logic_analyzer_trig #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              stop,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [ADDR_W-1:0] post_cnt,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W:0]   sample_cnt,
    output logic [7:0]        sts
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] post_left;
    logic [ADDR_W-1:0] start_ptr;
    logic [ADDR_W-1:0] trig_ptr;
    logic              wrapped;
    logic              triggered;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              capturing;
    logic              wr_en;
    logic              match;
    logic              fire;
    logic              finish;
    logic [ADDR_W-1:0] wr_ptr_next;
    logic [ADDR_W:0]   cnt_next;
    logic              wrapped_next;
    logic [ADDR_W-1:0] trig_ptr_next;
    logic [ADDR_W-1:0] start_next;
    logic [ADDR_W-1:0] rd_index;

    always_comb begin
        capturing     = (state == ARMED) || (state == POST);
        wr_en         = capturing && sample_en;
        match         = sample_en && (((data_in ^ trig_value) & trig_mask) == '0);
        // stop outranks a coincident trigger, so the trigger never fires with it
        fire          = (state == ARMED) && match && !stop;
        wr_ptr_next   = wr_en ? wr_ptr + 1'b1 : wr_ptr;
        cnt_next      = (wr_en && (sample_cnt != FULL)) ? sample_cnt + 1'b1 : sample_cnt;
        wrapped_next  = wrapped || (cnt_next == FULL);
        trig_ptr_next = fire ? wr_ptr : trig_ptr;
        start_next    = wrapped_next ? wr_ptr_next : '0;
        finish        = capturing && (stop
                        || (fire && (post_left == '0))
                        || ((state == POST) && wr_en && (post_left == ADDR_W'(1))));
        rd_index      = (state == DONE) ? rd_addr + start_ptr : rd_addr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            sample_cnt <= '0;
            wrapped    <= 1'b0;
            triggered  <= 1'b0;
            trig_addr  <= '0;
            trig_ptr   <= '0;
            post_left  <= '0;
            start_ptr  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        wr_ptr     <= '0;
                        sample_cnt <= '0;
                        wrapped    <= 1'b0;
                        triggered  <= 1'b0;
                        trig_ptr   <= '0;
                        post_left  <= post_cnt;
                        state      <= ARMED;
                    end
                end
                default: begin
                    wr_ptr     <= wr_ptr_next;
                    sample_cnt <= cnt_next;
                    wrapped    <= wrapped_next;
                    trig_ptr   <= trig_ptr_next;
                    if (fire) begin
                        triggered <= 1'b1;
                    end
                    if ((state == POST) && wr_en) begin
                        post_left <= post_left - 1'b1;
                    end
                    if (finish) begin
                        state     <= DONE;
                        start_ptr <= start_next;
                        trig_addr <= trig_ptr_next - start_next;
                    end else if (fire) begin
                        state <= POST;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_index];
        end
    end

    assign sts = {4'b0000, triggered, wrapped, state};

endmodule

// File: tb/tb_logic_analyzer_trig.sv
// Self-checking bench for logic_analyzer_trig: directed tables, hand sequences
// and a randomized run against a sample-history reference model.
module tb_logic_analyzer_trig;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        arm = 1'b0;
    logic        stop = 1'b0;
    logic        sample_en = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] trig_mask = '0;
    logic [31:0] trig_value = '0;
    logic [4:0]  post_cnt = '0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic [4:0]  trig_addr;
    logic [5:0]  sample_cnt;
    logic [7:0]  sts;

    logic_analyzer_trig #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop), .sample_en(sample_en),
        .data_in(data_in), .trig_mask(trig_mask), .trig_value(trig_value),
        .post_cnt(post_cnt), .rd_addr(rd_addr), .rd_data(rd_data),
        .trig_addr(trig_addr), .sample_cnt(sample_cnt), .sts(sts)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the full history of stored samples of the current capture.
    int          m_state;
    logic [31:0] m_hist[$];
    int          m_trig;
    int          m_post_left;

    typedef struct {
        logic        a;
        logic        s;
        logic        e;
        logic [31:0] d;
        logic [7:0]  exp_sts;
        logic [5:0]  exp_cnt;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_state = 0;
        m_hist.delete();
        m_trig = -1;
        m_post_left = 0;
    endfunction

    function automatic void model_step(input logic a, input logic s, input logic e,
                                       input logic [31:0] d);
        logic hit;
        hit = e && (((d ^ trig_value) & trig_mask) == 32'd0);
        if (m_state == 0 || m_state == 3) begin
            if (a) begin
                m_hist.delete();
                m_trig = -1;
                m_post_left = int'(post_cnt);
                m_state = 1;
            end
        end else begin
            if (e) m_hist.push_back(d);
            if (s) begin
                m_state = 3;
            end else if (m_state == 1 && hit) begin
                m_trig = m_hist.size() - 1;
                m_state = (m_post_left == 0) ? 3 : 2;
            end else if (m_state == 2 && e) begin
                m_post_left--;
                if (m_post_left == 0) m_state = 3;
            end
        end
    endfunction

    function automatic logic [7:0] exp_sts();
        int n;
        n = m_hist.size();
        return {4'b0000, (m_trig >= 0), (n >= 32), 2'(m_state)};
    endfunction

    function automatic logic [5:0] exp_cnt();
        int n;
        n = m_hist.size();
        return (n >= 32) ? 6'd32 : 6'(n);
    endfunction

    task automatic drive(input logic a, input logic s, input logic e, input logic [31:0] d);
        arm = a; stop = s; sample_en = e; data_in = d;
        model_step(a, s, e, d);
        @(negedge clk);
        chk("sts", 64'(sts), 64'(exp_sts()));
        chk("sample_cnt", 64'(sample_cnt), 64'(exp_cnt()));
    endtask

    task automatic readout_all();
        int n, k, base;
        n = m_hist.size();
        k = (n >= 32) ? 32 : n;
        base = n - k;
        for (int i = 0; i < k; i++) begin
            rd_addr = 5'(i);
            drive(1'b0, 1'b0, 1'b0, 32'd0);
            chk($sformatf("rd_data[%0d]", i), 64'(rd_data), 64'(m_hist[base + i]));
        end
        if (m_trig >= 0) chk("trig_addr", 64'(trig_addr), 64'(m_trig - base));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int q;
        int prev;
        logic a, s, e;
        logic [31:0] d;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,  8'h01, 6'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h55, 8'h0B, 6'd1};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 32'h0,  8'h0B, 6'd1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 32'h66, 8'h0B, 6'd1};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h77, 8'h0B, 6'd1};

        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_sts", 64'(sts), 64'h00);
        chk("reset_cnt", 64'(sample_cnt), 64'h00);
        chk("reset_rd_data", 64'(rd_data), 64'h00);
        chk("reset_trig_addr", 64'(trig_addr), 64'h00);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b1, 1'b1, 32'h1234);
        chk("idle_sts", 64'(sts), 64'h00);

        // Wrapped capture with a full-mask trigger and three post samples.
        trig_mask = 32'hFFFF_FFFF; trig_value = 32'hDEAD_BEEF; post_cnt = 5'd3;
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 40; i++) drive(1'b0, 1'b0, 1'b1, 32'(i));
        drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 32'(100 + i));
        chk("wrap_sts", 64'(sts), 64'h0F);
        chk("wrap_cnt", 64'(sample_cnt), 64'd32);
        readout_all();
        chk("wrap_trig_addr", 64'(trig_addr), 64'd28);

        // Zero mask, zero post: first qualified sample ends the capture.
        trig_mask = '0; post_cnt = 5'd0;
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].a, tbl[i].s, tbl[i].e, tbl[i].d);
            chk($sformatf("tbl_sts[%0d]", i), 64'(sts), 64'(tbl[i].exp_sts));
            chk($sformatf("tbl_cnt[%0d]", i), 64'(sample_cnt), 64'(tbl[i].exp_cnt));
        end
        readout_all();
        chk("single_trig_addr", 64'(trig_addr), 64'd0);

        // Stop without trigger.
        trig_mask = 32'hFFFF_FFFF; post_cnt = 5'd7;
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b1, 32'(1000 + i));
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        chk("stop_sts", 64'(sts), 64'h03);
        chk("stop_cnt", 64'(sample_cnt), 64'd10);
        rd_addr = 5'd0;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk("stop_rd0", 64'(rd_data), 64'd1000);

        // Sparse post samples with ignored arm pulses.
        post_cnt = 5'd5;
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 32'd1);
        drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("post_entry_sts", 64'(sts), 64'h0A);
        q = 0;
        for (int c = 0; c < 30 && q < 5; c++) begin
            e = (c % 3 == 2);
            drive((c % 4 == 1), 1'b0, e, 32'(200 + c));
            if (e) q++;
            chk("post_state", 64'(sts[1:0]), (q < 5) ? 64'd2 : 64'd3);
        end
        readout_all();

        // Reset in the middle of POST, then a normal capture.
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        drive(1'b0, 1'b0, 1'b1, 32'd7);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        chk("midpost_reset_sts", 64'(sts), 64'h00);
        chk("midpost_reset_cnt", 64'(sample_cnt), 64'd0);
        reset = 1'b0;
        post_cnt = 5'd2;
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 32'd11);
        drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        drive(1'b0, 1'b0, 1'b1, 32'd12);
        drive(1'b0, 1'b0, 1'b1, 32'd13);
        chk("after_reset_sts", 64'(sts), 64'h0B);
        readout_all();

        // Randomized run against the reference model.
        for (int c = 0; c < 2500; c++) begin
            if (m_state == 0 || m_state == 3) begin
                trig_mask  = $urandom & 32'h0000_00FF;
                trig_value = $urandom;
                post_cnt   = 5'($urandom_range(0, 31));
            end
            a = ($urandom_range(0, 5) == 0);
            s = ($urandom_range(0, 60) == 0);
            e = ($urandom_range(0, 3) != 0);
            d = $urandom;
            if ($urandom_range(0, 24) == 0) d = (d & ~trig_mask) | (trig_value & trig_mask);
            prev = m_state;
            drive(a, s, e, d);
            if (m_state == 3 && prev != 3) readout_all();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
